packet_serializer: RTL and testbench

PACKET_SERIALIZER -- requirements
Module: packet_serializer

---
 rtl/packet_serializer.sv | 116 +++++++++++
 tb/tb_packet_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// packet_serializer: splits a 24-bit header and four 56-bit subpackets into
// 32 bit-slices per packet. Each slice is a 9-bit payload word.
// The last slices of every stream carry BCH parity. The BCH value is built
// serially while the packet is being sent.
module packet_serializer (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island_period,
    input  logic [23:0] header,
    input  logic [55:0] sub [4],
    output logic [4:0]  counter,
    output logic [8:0]  packet_data,
    output logic        packet_end
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned ECC_W     = 8;
    localparam int unsigned NUM_SUB   = 4;
    localparam int unsigned HDR_LAST  = 23;   // last header data slice
    localparam int unsigned SUB_LAST  = 27;   // last subpacket data slice
    localparam int unsigned SLICE_END = 31;   // final slice of a packet

    localparam logic [ECC_W-1:0] BCH_POLY = 8'h83;

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [ECC_W-1:0] hdr_ecc_q, hdr_ecc_d;
    logic [ECC_W-1:0] sub_ecc_q [NUM_SUB];
    logic [ECC_W-1:0] sub_ecc_d [NUM_SUB];

    // Even and odd subpacket bit positions for the current slice.
    logic [5:0] even_idx;
    logic [5:0] odd_idx;

    // ECC bit-pair position for subpacket parity slices 28..31.
    logic [2:0] sub_ecc_idx;

    // One serial BCH step with generator 1+x^6+x^7+x^8. The LSB is the feedback tap.
    function automatic logic [ECC_W-1:0] bch_step(input logic [ECC_W-1:0] ecc,
                                                  input logic             b);
        bch_step = {1'b0, ecc[ECC_W-1:1]} ^ ((ecc[0] ^ b) ? BCH_POLY : '0);
    endfunction

    assign even_idx    = {counter_q, 1'b0};
    assign odd_idx     = {counter_q, 1'b1};
    assign sub_ecc_idx = {counter_q[1:0], 1'b0};

    // Next state for the slice counter and the ECC accumulators.
    always_comb begin
        counter_d = '0;
        hdr_ecc_d = hdr_ecc_q;
        sub_ecc_d = sub_ecc_q;

        if (data_island_period) begin
            counter_d = counter_q + CNT_W'(1);
        end

        if (!data_island_period || counter_q == CNT_W'(SLICE_END)) begin
            hdr_ecc_d = '0;
            for (int k = 0; k < NUM_SUB; k++) begin
                sub_ecc_d[k] = '0;
            end
        end else begin
            if (counter_q <= CNT_W'(HDR_LAST)) begin
                hdr_ecc_d = bch_step(hdr_ecc_q, header[counter_q]);
            end
            if (counter_q <= CNT_W'(SUB_LAST)) begin
                for (int k = 0; k < NUM_SUB; k++) begin
                    sub_ecc_d[k] = bch_step(bch_step(sub_ecc_q[k], sub[k][even_idx]),
                                            sub[k][odd_idx]);
                end
            end
        end
    end

    // State registers. The asynchronous reset clears them at once, which drops any partial packet.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            hdr_ecc_q <= '0;
            for (int k = 0; k < NUM_SUB; k++) begin
                sub_ecc_q[k] <= '0;
            end
        end else begin
            counter_q <= counter_d;
            hdr_ecc_q <= hdr_ecc_d;
            for (int k = 0; k < NUM_SUB; k++) begin
                sub_ecc_q[k] <= sub_ecc_d[k];
            end
        end
    end

    // Slice payload mux. Data bits come first, then the held parity with no added latency.
    always_comb begin
        packet_data = '0;

        if (counter_q <= CNT_W'(HDR_LAST)) begin
            packet_data[0] = header[counter_q];
        end else begin
            packet_data[0] = hdr_ecc_q[counter_q[2:0]];
        end

        for (int k = 0; k < NUM_SUB; k++) begin
            if (counter_q <= CNT_W'(SUB_LAST)) begin
                packet_data[1+k] = sub[k][even_idx];
                packet_data[5+k] = sub[k][odd_idx];
            end else begin
                packet_data[1+k] = sub_ecc_q[k][sub_ecc_idx];
                packet_data[5+k] = sub_ecc_q[k][sub_ecc_idx + 3'd1];
            end
        end
    end

    assign counter    = counter_q;
    assign packet_end = data_island_period && (counter_q == CNT_W'(SLICE_END));

endmodule

// File: tb/tb_packet_serializer.sv
// Testbench for packet_serializer. It uses directed and randomized
// stimulus and checks every slice against a packet-level reference model.
module tb_packet_serializer;

    logic        clk_pixel;
    logic        reset;
    logic        data_island_period;
    logic [23:0] header;
    logic [55:0] sub [4];
    logic [4:0]  counter;
    logic [8:0]  packet_data;
    logic        packet_end;

    packet_serializer dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .counter            (counter),
        .packet_data        (packet_data),
        .packet_end         (packet_end)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int checks;
    int failures;

    // Stimulus for the next cycle.
    logic        rst_s;
    logic        dip_s;
    logic [23:0] hdr_s;
    logic [55:0] sub_s [4];

    // Model state: the slice index that the DUT should show.
    int m_cnt;
    int lit_mode;
    int cyc;
    int pe_cycles[$];
    logic [7:0] lit83;
    int lit_sub[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // BCH of the first n bits of a whole message, sent LSB first, with seed 0.
    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (e[0] ^ bits[i]) e = {1'b0, e[7:1]} ^ 8'h83;
            else                e = {1'b0, e[7:1]};
        end
        return e;
    endfunction

    // Expected payload for slice c. It assumes the inputs are held over the packet.
    function automatic logic [8:0] model_pd(input int c);
        logic [8:0] r;
        logic [7:0] e;
        r = '0;
        if (c < 24) r[0] = hdr_s[c];
        else begin
            e = bch(64'(hdr_s), 24);
            r[0] = e[c-24];
        end
        for (int k = 0; k < 4; k++) begin
            if (c < 28) begin
                r[1+k] = sub_s[k][2*c];
                r[5+k] = sub_s[k][2*c+1];
            end else begin
                e = bch(64'(sub_s[k]), 56);
                r[1+k] = e[2*(c-28)];
                r[5+k] = e[2*(c-28)+1];
            end
        end
        return r;
    endfunction

    // One pixel cycle. Drive at negedge, compare mid-low-phase, then advance the model.
    task automatic step();
        @(negedge clk_pixel);
        reset              = rst_s;
        data_island_period = dip_s;
        header             = hdr_s;
        for (int k = 0; k < 4; k++) sub[k] = sub_s[k];
        #1;
        if (rst_s) m_cnt = 0;
        chk("counter", 32'(counter), 32'(m_cnt));
        chk("packet_end", 32'(packet_end), 32'(dip_s && m_cnt == 31));
        chk("packet_data", 32'(packet_data), 32'(model_pd(m_cnt)));
        if (lit_mode == 1 && m_cnt >= 24)
            chk("hdr_ecc_lit", 32'(packet_data[0]), 32'(lit83[m_cnt-24]));
        if (lit_mode == 1 && m_cnt >= 28)
            chk("hdr_test_sub_zero", 32'(packet_data[8:1]), 32'(0));
        if (lit_mode == 2 && m_cnt >= 28) begin
            chk("sub0_ecc_lit", 32'({packet_data[5], packet_data[1]}), 32'(lit_sub[m_cnt-28]));
            chk("sub_other_zero", 32'({packet_data[8:6], packet_data[4:2]}), 32'(0));
        end
        if (lit_mode == 3)
            chk("zero_packet", 32'(packet_data), 32'(0));
        if (packet_end) pe_cycles.push_back(cyc);
        cyc++;
        m_cnt = (rst_s || !dip_s) ? 0 : (m_cnt + 1) % 32;
    endtask

    task automatic rand_data();
        hdr_s = 24'($urandom());
        for (int k = 0; k < 4; k++) sub_s[k] = 56'({$urandom(), $urandom()});
    endtask

    task automatic zero_data();
        hdr_s = '0;
        for (int k = 0; k < 4; k++) sub_s[k] = '0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; m_cnt = 0; lit_mode = 0;
        lit83 = 8'h83;
        lit_sub = '{3, 0, 0, 2};
        rst_s = 1'b1; dip_s = 1'b0;
        zero_data();
        reset = 1'b1; data_island_period = 1'b0; header = '0;
        for (int k = 0; k < 4; k++) sub[k] = '0;

        // Reset state. The outputs reflect slice 0 even with random inputs and data_island_period high.
        repeat (2) step();
        rand_data(); dip_s = 1'b1;
        repeat (3) step();

        // Release with data_island_period low, then run two back-to-back zero packets.
        rst_s = 1'b0; dip_s = 1'b0;
        step();
        zero_data(); dip_s = 1'b1;
        pe_cycles.delete(); cyc = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("cnt_seq", 32'(counter), 32'(i % 32));
        end
        chk("pe_count", 32'(pe_cycles.size()), 32'(2));
        if (pe_cycles.size() == 2) begin
            chk("pe_first", 32'(pe_cycles[0]), 32'(31));
            chk("pe_second", 32'(pe_cycles[1]), 32'(63));
        end

        // Pin the model itself.
        chk("model_bch_hdr", 32'(bch(64'h800000, 24)), 32'h83);
        chk("model_bch_sub", 32'(bch(64'h80000000000000, 56)), 32'h83);
        chk("model_bch_zero", 32'(bch(64'h0, 56)), 32'h00);

        // Single header MSB set.
        lit_mode = 1; hdr_s = 24'h800000;
        repeat (32) step();
        // Single sub[0] MSB set.
        lit_mode = 2; hdr_s = '0; sub_s[0] = 56'h80000000000000;
        repeat (32) step();
        // All-zero packet.
        lit_mode = 3; sub_s[0] = '0;
        repeat (32) step();

        // Abort at slice 12, then an all-zero packet must carry zero ECC.
        lit_mode = 0; rand_data();
        repeat (12) step();
        dip_s = 1'b0;
        step();
        chk("abort_at_12", 32'(counter), 32'(12));
        dip_s = 1'b1; zero_data(); lit_mode = 3;
        step();
        chk("restart_cnt", 32'(counter), 32'(0));
        repeat (31) step();

        // Asynchronous reset at slice 20, between edges.
        lit_mode = 0; rand_data();
        repeat (20) step();
        @(posedge clk_pixel);
        #2;
        chk("pre_reset_cnt", 32'(counter), 32'(20));
        reset = 1'b1; rst_s = 1'b1;
        #1;
        m_cnt = 0;
        chk("async_rst_cnt", 32'(counter), 32'(0));
        chk("async_rst_pe", 32'(packet_end), 32'(0));
        chk("async_rst_pd", 32'(packet_data), 32'(model_pd(0)));
        repeat (2) step();
        rst_s = 1'b0; zero_data(); lit_mode = 3;
        repeat (32) step();

        // Random phase.
        lit_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (m_cnt == 0) begin
                if ($urandom_range(3) == 0) zero_data();
                else rand_data();
            end
            dip_s = ($urandom_range(39) != 0);
            rst_s = ($urandom_range(249) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
